// File: rtl/mod_reduce_512_seq.sv
// Sequential reducer: 512-bit product -> product mod MODULUS using restoring
// shift-subtract, absorbing STEPS_PER_CYCLE product bits per clock, MSB first.
module mod_reduce_512_seq #(
    parameter logic [255:0] MODULUS         = 256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED,
    parameter int           STEPS_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] product,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] result,
    output logic         busy
);

    localparam int             N        = 512 / STEPS_PER_CYCLE;
    localparam logic [8:0]     CNT_LOAD = 9'(N - 1);
    localparam logic [256:0]   MOD_EXT  = {1'b0, MODULUS};

    generate
        if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 ||
              STEPS_PER_CYCLE == 4 || STEPS_PER_CYCLE == 8) || (MODULUS < 256'd2)) begin : g_bad_params
            $error("mod_reduce_512_seq: STEPS_PER_CYCLE must be 1, 2, 4 or 8 and MODULUS >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [511:0]   sh_q, sh_d;
    logic [256:0]   r_q, r_d;
    logic [8:0]     cnt_q, cnt_d;
    logic [255:0]   result_q, result_d;
    logic [256:0]   r_step;
    logic [511:0]   sh_step;

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        // r stays below MODULUS after every step, so 2r+1 always fits in 257 bits.
        r_step  = r_q;
        sh_step = sh_q;
        for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
            r_step  = {r_step[255:0], sh_step[511]};
            sh_step = {sh_step[510:0], 1'b0};
            if (r_step >= MOD_EXT) begin
                r_step = r_step - MOD_EXT;
            end
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sh_d    = product;
                    r_d     = '0;
                    cnt_d   = CNT_LOAD;
                    state_d = RUN;
                end
            end
            RUN: begin
                sh_d = sh_step;
                r_d  = r_step;
                if (cnt_q == 9'd0) begin
                    result_d = r_step[255:0];
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - 9'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sh_q     <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Handshake outputs decode registered state only.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;

endmodule

// File: tb/tb_mod_reduce_512_seq.sv
// Scoreboard bench for mod_reduce_512_seq: four DUT lanes (default params with
// directed cases, plus STEPS 1/2/8 at MODULUS 2^256-189 with random sweeps).
module tb_mod_reduce_512_seq;

    localparam logic [255:0] MOD_DEF = 256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;
    localparam logic [255:0] MOD_ALT = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF43;

    logic clk = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        logic [255:0] expv;
        int           acc;
    } sb_t;

    // Free-running clock and a cycle counter used to timestamp accepts and outputs.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input int lane, input string name,
                               input logic [511:0] actual, input logic [511:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL lane%0d %s: got %0h, want %0h", lane, name, actual, expected);
        end
    endtask

    task automatic noteTimeout(input int lane, input string name);
        total++;
        bad++;
        $display("[TB] FAIL lane%0d %s: bound expired or unexpected event", lane, name);
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : lane
        localparam int           S      = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 8;
        localparam int           N      = 512 / S;
        localparam logic [255:0] M      = (g == 0) ? MOD_DEF : MOD_ALT;
        localparam int           NITEMS = (g == 0) ? 40 : (g == 1) ? 40 : (g == 2) ? 80 : 300;

        logic         rst_n, in_valid, in_ready, out_valid, out_ready, busy;
        logic [511:0] product;
        logic [255:0] result;
        logic         done = 1'b0;
        int           last_acc = 0;
        sb_t          sb[$];

        mod_reduce_512_seq #(
            .MODULUS        (M),
            .STEPS_PER_CYCLE(S)
        ) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .product  (product),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .result   (result),
            .busy     (busy)
        );

        // Reference model: plain wide modulo of the whole product.
        function automatic logic [255:0] refMod(input logic [511:0] p);
            logic [511:0] r;
            r = p % {256'b0, M};
            return r[255:0];
        endfunction

        function automatic logic [511:0] pickProduct(input int i);
            logic [511:0] p;
            case (i % 10)
                3:       p = '1;
                5:       p = '0;
                7:       p = {256'b0, M} * 512'($urandom_range(1, 1000)) + 512'($urandom_range(0, 3));
                default: p = rnd512();
            endcase
            return p;
        endfunction

        // Present one product and hold it until accepted; the expected result and
        // the accept cycle go to the scoreboard at the moment of acceptance.
        task automatic applyStimulus(input logic [511:0] p, input logic [255:0] e);
            int guard;
            guard    = 0;
            in_valid = 1'b1;
            product  = p;
            @(negedge clk);
            while (!in_ready && guard < 2000) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) begin
                noteTimeout(g, "accept");
                in_valid = 1'b0;
                return;
            end
            sb.push_back('{e, cyc});
            last_acc = cyc;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        endtask

        task automatic drain();
            for (int k = 0; k < 3000 && sb.size() != 0; k++) @(negedge clk);
            if (sb.size() != 0) noteTimeout(g, "drain");
            @(posedge clk);
            #1;
        endtask

        // Monitor: pops the scoreboard on every output transfer and checks that a
        // stalled output keeps its value and keeps the input side closed.
        initial begin : monitor
            logic         holding, rise_seen;
            logic [255:0] held;
            int           rise_cyc;
            sb_t          e;
            holding = 1'b0; rise_seen = 1'b0; held = '0; rise_cyc = 0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    holding   = 1'b0;
                    rise_seen = 1'b0;
                end else begin
                    if (holding) begin
                        checkOutput(g, "hold_out_valid", 512'(out_valid), 512'd1);
                        checkOutput(g, "hold_result", 512'(result), 512'(held));
                        checkOutput(g, "hold_in_ready", 512'(in_ready), 512'd0);
                    end
                    holding = 1'b0;
                    if (out_valid) begin
                        if (!rise_seen) begin
                            rise_seen = 1'b1;
                            rise_cyc  = cyc;
                        end
                        if (out_ready) begin
                            if (sb.size() == 0) begin
                                noteTimeout(g, "spurious_output");
                            end else begin
                                e = sb.pop_front();
                                checkOutput(g, "result", 512'(result), 512'(e.expv));
                                checkOutput(g, "latency", 512'(rise_cyc - e.acc), 512'(N + 1));
                            end
                            rise_seen = 1'b0;
                        end else begin
                            holding = 1'b1;
                            held    = result;
                        end
                    end
                end
            end
        end

        if (g == 0) begin : directed
            // Directed cases: reset values, corner products, backpressure, reset mid-run.
            initial begin
                logic [511:0] p;
                rst_n = 1'b1; in_valid = 1'b0; product = '0; out_ready = 1'b1;
                #2 rst_n = 1'b0;
                @(negedge clk);
                checkOutput(g, "reset_out_valid", 512'(out_valid), 512'd0);
                checkOutput(g, "reset_busy", 512'(busy), 512'd0);
                checkOutput(g, "reset_result", 512'(result), 512'd0);
                checkOutput(g, "reset_in_ready", 512'(in_ready), 512'd1);
                @(posedge clk); #1 rst_n = 1'b1;
                @(posedge clk); #1;

                applyStimulus('0, 256'd0);
                checkOutput(g, "run_busy", 512'(busy), 512'd1);
                applyStimulus({256'b0, M}, 256'd0);
                applyStimulus(512'd5, 256'd5);
                p = {256'b0, M - 256'd1};
                applyStimulus(p * p, 256'd1);
                applyStimulus('1, 256'd1443);
                drain();

                out_ready = 1'b0;
                p = rnd512();
                applyStimulus(p, refMod(p));
                for (int k = 0; k < N + 10 && !out_valid; k++) @(negedge clk);
                if (!out_valid) noteTimeout(g, "bp_out_valid");
                for (int k = 0; k < 20; k++) begin
                    @(posedge clk); #1;
                    in_valid = ~in_valid;
                    product  = rnd512();
                end
                @(posedge clk); #1;
                in_valid  = 1'b0;
                out_ready = 1'b1;
                @(negedge clk);
                @(negedge clk);
                checkOutput(g, "release_in_ready", 512'(in_ready), 512'd1);
                checkOutput(g, "release_out_valid", 512'(out_valid), 512'd0);
                @(posedge clk); #1;

                p = rnd512();
                applyStimulus(p, refMod(p));
                repeat (59) @(posedge clk);
                #3;
                checkOutput(g, "pre_reset_busy", 512'(busy), 512'd1);
                rst_n = 1'b0;
                #1;
                checkOutput(g, "midreset_out_valid", 512'(out_valid), 512'd0);
                checkOutput(g, "midreset_busy", 512'(busy), 512'd0);
                checkOutput(g, "midreset_result", 512'(result), 512'd0);
                checkOutput(g, "midreset_in_ready", 512'(in_ready), 512'd1);
                sb.delete();
                @(posedge clk); #1 rst_n = 1'b1;
                @(posedge clk); #1;
                applyStimulus({256'b0, M} * 512'd7 + 512'd3, 256'd3);

                for (int i = 0; i < NITEMS; i++) begin
                    p = pickProduct(i);
                    applyStimulus(p, refMod(p));
                end
                drain();
                done = 1'b1;
            end
        end else begin : sweep
            // Random sweep, back-to-back with the consumer always ready.
            initial begin
                logic [511:0] p;
                int           prev_acc;
                rst_n = 1'b1; in_valid = 1'b0; product = '0; out_ready = 1'b1;
                #2 rst_n = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                @(posedge clk); #1;
                for (int i = 0; i < NITEMS; i++) begin
                    prev_acc = last_acc;
                    p = pickProduct(i);
                    applyStimulus(p, refMod(p));
                    if (i > 0) checkOutput(g, "interval", 512'(last_acc - prev_acc), 512'(N + 2));
                end
                drain();
                done = 1'b1;
            end
        end
    end

    // Wait for every lane to finish, then print the summary.
    initial begin
        for (int k = 0; k < 90000; k++) begin
            @(posedge clk);
            if (lane[0].done && lane[1].done && lane[2].done && lane[3].done) break;
        end
        if (!(lane[0].done && lane[1].done && lane[2].done && lane[3].done)) noteTimeout(-1, "global");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
